gameplay_datapath: RTL and testbench
====================================

GAMEPLAY_DATAPATH -- requirements
Module: gameplay_datapath

Interface
REQ-001 Parameter SCREEN_W, default 160, SHALL be the playfield width in pixels.
REQ-002 Parameter BLOCK_W, default 20, SHALL be the moving block width in pixels.
REQ-003 Parameter ROW_H, default 8, SHALL be the row height in pixels.
REQ-004 Parameter Y_BOTTOM, default 112, SHALL be the y coordinate of row 0.
REQ-005 Parameter NUM_ROWS, default 15, SHALL be the row count; row index saturates at NUM_ROWS-1.
REQ-006 Parameter INIT_CHANCES, default 3, SHALL be the chances loaded at new game.
REQ-007 Parameters BASE_DIV (1_000_000), DIV_STEP (50_000) and MIN_DIV (200_000) SHALL define the shift-tick period in clocks.
REQ-008 The design SHALL have one clock; reset is asynchronous and active-low; clock port is clk, reset port is resetn.
REQ-009 clk  in  1  system clock.
REQ-010 resetn  in  1  asynchronous active-low reset.
REQ-011 ld_x, ld_y, ld_d, ld_df  in  1 each  load x / y / direction / difficulty.
REQ-012 enable  in  1  permit x shifting.
REQ-013 save_x, inc_row, inc_score, dec_chances  in  1 each  datapath update strobes.
REQ-014 game_over  in  1  high while the controller reports game status 2'b10.
REQ-015 x_out  out  8  left edge of moving block.
REQ-016 y_out  out  7  top of current row.
REQ-017 prev_x  out  8  left edge of last placed block.
REQ-018 row  out  4  current row index.
REQ-019 score  out  8  score.
REQ-020 chances  out  2  remaining chances.
REQ-021 c  out  1  chances != 0.
REQ-022 o  out  1  placement acceptable (overlap or first row).

Function
REQ-023 ld_x SHALL set x to 0 and clear the tick counter; ld_d SHALL set direction to right.
REQ-024 ld_y SHALL register y_out = Y_BOTTOM - row*ROW_H, using row value before any same-cycle inc_row.
REQ-025 ld_df SHALL register period = max(MIN_DIV, BASE_DIV - row*DIV_STEP), without underflow, and clear the tick counter.
REQ-026 While enable=1 the tick counter SHALL count 0..period-1 and then wrap; the wrap cycle is a tick. While enable=0 the counter and x SHALL hold.
REQ-027 On a tick moving right: x+1, except at x==SCREEN_W-BLOCK_W, where direction flips to left and x-1.
REQ-028 On a tick moving left: x-1, except at x==0, where direction flips to right and x+1.
REQ-029 Invariant: x SHALL always stay in 0..SCREEN_W-BLOCK_W.
REQ-030 Priority on x: ld_x over tick; ld_d over a tick-induced direction flip.
REQ-031 save_x SHALL set prev_x to the current x (the pre-update value if ld_x is in the same cycle) and set internal prev_valid=1.
REQ-032 inc_row SHALL increment row, saturating at NUM_ROWS-1.
REQ-033 inc_score SHALL increment score, saturating at 255.
REQ-034 dec_chances SHALL decrement chances, saturating at 0.
REQ-035 o SHALL be combinational: 1 if prev_valid==0, else 1 when |x - prev_x| < BLOCK_W, else 0.
REQ-036 c SHALL be combinational (chances != 0).
REQ-037 While game_over=1, the block SHALL clear row, score and prev_valid, and load chances=INIT_CHANCES. These clears override same-cycle strobes on those registers.
REQ-038 All registered outputs SHALL update on the rising edge of clk.

Reset
REQ-039 resetn=0 SHALL asynchronously set x=0, direction=right, y_out=Y_BOTTOM, prev_x=0, prev_valid=0, row=0, score=0, chances=INIT_CHANCES, period=BASE_DIV, tick counter=0.
REQ-040 Reset asserted mid-shift SHALL abort immediately; first tick after release SHALL occur period clocks after enable.

Verification
REQ-041 Test: override BASE_DIV=2; ld_x/ld_d, then enable held -> x steps 0,1,..,140 every 2 clocks, then 139; direction flips at 140 and at 0.
REQ-042 Test: save_x at x=50, later x=69 -> o=1; x=70 -> o=0; x=31 -> o=1; x=30 -> o=0.
REQ-043 Test: after reset, o=1 at any x; dec_chances x4 -> chances 2,1,0,0; c falls when chances reaches 0.
REQ-044 Test: inc_row x3 then ld_y, ld_df -> y_out=88, period=850_000; inc_row x20 -> row=14, period=300_000.
REQ-045 Test: score=255 plus inc_score -> 255; game_over pulse -> score=0, row=0, chances=3, o=1.
REQ-046 Test: ld_x together with a tick and save_x -> x=0, prev_x = old x.

Source files
------------

// File: rtl/gameplay_datapath.sv
// Datapath for a stacking-block game: moves a block back and forth across
// the playfield, tracks the current row, score and remaining chances, and
// reports whether the block overlaps the previously placed one.
module gameplay_datapath #(
  parameter int SCREEN_W     = 160,
  parameter int BLOCK_W      = 20,
  parameter int ROW_H        = 8,
  parameter int Y_BOTTOM     = 112,
  parameter int NUM_ROWS     = 15,
  parameter int INIT_CHANCES = 3,
  parameter int BASE_DIV     = 1_000_000,
  parameter int DIV_STEP     = 50_000,
  parameter int MIN_DIV      = 200_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ld_x,
  input  logic       ld_y,
  input  logic       ld_d,
  input  logic       ld_df,
  input  logic       enable,
  input  logic       save_x,
  input  logic       inc_row,
  input  logic       inc_score,
  input  logic       dec_chances,
  input  logic       game_over,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [7:0] prev_x,
  output logic [3:0] row,
  output logic [7:0] score,
  output logic [1:0] chances,
  output logic       c,
  output logic       o
);

  localparam int X_MAX = SCREEN_W - BLOCK_W;
  localparam int P_MAX = (BASE_DIV > MIN_DIV) ? BASE_DIV : MIN_DIV;
  localparam int CW    = $clog2(P_MAX + 1);

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  dir_t          dir;
  logic [CW-1:0] tick_cnt;
  logic [CW-1:0] period;
  logic [CW-1:0] period_calc;
  logic [6:0]    y_calc;
  logic [7:0]    x_step;
  logic          flip;
  logic          tick;
  logic          prev_valid;
  logic [8:0]    dx;
  int            row_drop;

  // A tick is the cycle in which the enabled counter wraps.
  assign tick = enable && (tick_cnt == period - CW'(1));

  // Row-dependent speed and row height; period clamps at MIN_DIV without
  // ever forming a negative intermediate.
  always_comb begin
    // NOTE: every signal driven here gets a value before any branch, so no
    // path can leave it unassigned and infer a latch.
    row_drop    = int'(row) * DIV_STEP;
    period_calc = CW'(MIN_DIV);
    if (row_drop + MIN_DIV < BASE_DIV)
      period_calc = CW'(BASE_DIV - row_drop);
    y_calc = 7'(Y_BOTTOM - int'(row) * ROW_H);
  end

  // Next x on a tick, bouncing off either wall.
  always_comb begin
    x_step = x_out;
    flip   = 1'b0;
    if (dir == DIR_RIGHT) begin
      if (x_out == 8'(X_MAX)) begin
        x_step = x_out - 8'd1;
        flip   = 1'b1;
      end else begin
        x_step = x_out + 8'd1;
      end
    end else begin
      if (x_out == 8'd0) begin
        x_step = x_out + 8'd1;
        flip   = 1'b1;
      end else begin
        x_step = x_out - 8'd1;
      end
    end
  end

  // Shift-tick counter; loads of x or difficulty restart the count.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values of its neighbours, independent of block ordering.
    if (!resetn)            tick_cnt <= '0;
    else if (ld_x || ld_df) tick_cnt <= '0;
    else if (enable)        tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
  end

  // Block position and direction; ld_x beats the tick, ld_d beats a flip.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_out <= 8'd0;
      dir   <= DIR_RIGHT;
    end else begin
      if (ld_x)      x_out <= 8'd0;
      else if (tick) x_out <= x_step;
      if (ld_d)
        dir <= DIR_RIGHT;
      else if (tick && !ld_x && flip)
        dir <= (dir == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
    end
  end

  // Row-derived registers, sampled from the row value before any increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      y_out  <= 7'(Y_BOTTOM);
      period <= CW'(BASE_DIV);
    end else begin
      if (ld_y)  y_out  <= y_calc;
      if (ld_df) period <= period_calc;
    end
  end

  // Placement memory, progress counters and chances; game over wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_x     <= 8'd0;
      prev_valid <= 1'b0;
      row        <= 4'd0;
      score      <= 8'd0;
      chances    <= 2'(INIT_CHANCES);
    end else begin
      if (save_x) prev_x <= x_out;
      if (game_over) begin
        prev_valid <= 1'b0;
        row        <= 4'd0;
        score      <= 8'd0;
        chances    <= 2'(INIT_CHANCES);
      end else begin
        if (save_x) prev_valid <= 1'b1;
        if (inc_row && row != 4'(NUM_ROWS - 1)) row <= row + 4'd1;
        if (inc_score && score != 8'hFF)        score <= score + 8'd1;
        if (dec_chances && chances != 2'd0)     chances <= chances - 2'd1;
      end
    end
  end

  // Overlap test against the last placed block, plus chances-left flag.
  always_comb begin
    dx = (x_out >= prev_x) ? {1'b0, x_out - prev_x} : {1'b0, prev_x - x_out};
    o  = !prev_valid || (dx < 9'(BLOCK_W));
    c  = (chances != 2'd0);
  end

endmodule

// File: tb/tb_gameplay_datapath.sv
// Randomised and directed bench for gameplay_datapath, checked against a
// behavioural model of the game rules.
module tb_gameplay_datapath;

  localparam int SCREEN_W     = 160;
  localparam int BLOCK_W      = 20;
  localparam int ROW_H        = 8;
  localparam int Y_BOTTOM     = 112;
  localparam int NUM_ROWS     = 15;
  localparam int INIT_CHANCES = 3;
  localparam int BASE_DIV     = 12;
  localparam int DIV_STEP     = 1;
  localparam int MIN_DIV      = 2;
  localparam int X_MAX        = SCREEN_W - BLOCK_W;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ld_x = 0, ld_y = 0, ld_d = 0, ld_df = 0, enable = 0;
  logic       save_x = 0, inc_row = 0, inc_score = 0, dec_chances = 0, game_over = 0;
  logic [7:0] x_out, prev_x, score;
  logic [6:0] y_out;
  logic [3:0] row;
  logic [1:0] chances;
  logic       c, o;

  always #5 clk = ~clk;

  gameplay_datapath #(
    .SCREEN_W(SCREEN_W), .BLOCK_W(BLOCK_W), .ROW_H(ROW_H), .Y_BOTTOM(Y_BOTTOM),
    .NUM_ROWS(NUM_ROWS), .INIT_CHANCES(INIT_CHANCES), .BASE_DIV(BASE_DIV),
    .DIV_STEP(DIV_STEP), .MIN_DIV(MIN_DIV)
  ) dut (
    .clk(clk), .resetn(resetn), .ld_x(ld_x), .ld_y(ld_y), .ld_d(ld_d), .ld_df(ld_df),
    .enable(enable), .save_x(save_x), .inc_row(inc_row), .inc_score(inc_score),
    .dec_chances(dec_chances), .game_over(game_over), .x_out(x_out), .y_out(y_out),
    .prev_x(prev_x), .row(row), .score(score), .chances(chances), .c(c), .o(o)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: plain integers following the game rules.
  int m_x, m_cnt, m_period, m_y, m_px, m_row, m_score, m_ch;
  bit m_right, m_pv;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", tag);
  endtask

  function automatic void model_reset();
    m_x = 0; m_right = 1; m_cnt = 0; m_period = BASE_DIV; m_y = Y_BOTTOM;
    m_px = 0; m_pv = 0; m_row = 0; m_score = 0; m_ch = INIT_CHANCES;
  endfunction

  function automatic void model_step();
    int  ox   = m_x;
    int  orow = m_row;
    int  nd;
    bit  tick = enable && ((m_cnt + 1) % m_period == 0);
    bit  bounce = 0;
    if (ld_x || ld_df) m_cnt = 0;
    else if (enable)   m_cnt = (m_cnt + 1) % m_period;
    if (ld_x) m_x = 0;
    else if (tick) begin
      nd = m_right ? 1 : -1;
      if (ox + nd < 0 || ox + nd > X_MAX) begin nd = -nd; bounce = 1; end
      m_x = ox + nd;
    end
    if (ld_d) m_right = 1;
    else if (bounce) m_right = !m_right;
    if (ld_y)  m_y = Y_BOTTOM - orow * ROW_H;
    if (ld_df) m_period = (BASE_DIV - orow * DIV_STEP > MIN_DIV) ? BASE_DIV - orow * DIV_STEP : MIN_DIV;
    if (save_x) begin m_px = ox; m_pv = 1; end
    if (inc_row)     m_row   = (m_row + 1 > NUM_ROWS - 1) ? NUM_ROWS - 1 : m_row + 1;
    if (inc_score)   m_score = (m_score + 1 > 255) ? 255 : m_score + 1;
    if (dec_chances) m_ch    = (m_ch - 1 < 0) ? 0 : m_ch - 1;
    if (game_over) begin m_row = 0; m_score = 0; m_pv = 0; m_ch = INIT_CHANCES; end
  endfunction

  function automatic int exp_o();
    int d = (m_x > m_px) ? m_x - m_px : m_px - m_x;
    return (!m_pv || d < BLOCK_W) ? 1 : 0;
  endfunction

  task automatic compare_all();
    check("x_out", x_out, m_x);
    check("y_out", y_out, m_y);
    check("prev_x", prev_x, m_px);
    check("row", row, m_row);
    check("score", score, m_score);
    check("chances", chances, m_ch);
    check("c", c, (m_ch != 0) ? 1 : 0);
    check("o", o, exp_o());
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    ld_x = 0; ld_y = 0; ld_d = 0; ld_df = 0; enable = 0;
    save_x = 0; inc_row = 0; inc_score = 0; dec_chances = 0; game_over = 0;
  endtask

  // Shift with enable held until x_out reaches target.
  task automatic run_until(input int target, input string tag);
    int n = 0;
    enable = 1;
    while (x_out != 8'(target) && n < 2000) begin step(); n++; end
    if (x_out != 8'(target)) timeout(tag);
  endtask

  // Step until x_out differs from its current value; returns the new value.
  task automatic next_x(output int nx, input string tag);
    int n = 0;
    logic [7:0] start = x_out;
    enable = 1;
    while (x_out == start && n < 200) begin step(); n++; end
    if (x_out == start) timeout(tag);
    nx = int'(x_out);
  endtask

  // Restart from x=0 and count enabled clocks up to the first move.
  task automatic measure_tick(output int n, input string tag);
    ld_x = 1; ld_d = 1; step(); ld_x = 0; ld_d = 0;
    enable = 1; n = 0;
    while (x_out == 8'd0 && n < 200) begin step(); n++; end
    if (x_out == 8'd0) timeout(tag);
    enable = 0;
  endtask

  initial begin
    int n, v, old;
    model_reset();
    #22;
    compare_all();
    check("rst_y", y_out, Y_BOTTOM);
    check("rst_chances", chances, INIT_CHANCES);
    @(negedge clk) resetn = 1;

    // o is always 1 before any placement; chances count down and saturate.
    run_until(5, "to_x5");
    check("o_noprev", o, 1);
    enable = 0;
    for (int i = 0; i < 4; i++) begin
      dec_chances = 1; step(); dec_chances = 0;
      check("dec_chances", chances, (i < 3) ? 2 - i : 0);
      check("dec_c", c, (i < 2) ? 1 : 0);
    end

    // Row height and speed follow the row; period clamps at MIN_DIV.
    game_over = 1; step(); game_over = 0;
    inc_row = 1; repeat (3) step(); inc_row = 0;
    ld_y = 1; ld_df = 1; step(); ld_y = 0; ld_df = 0;
    check("y_row3", y_out, 88);
    measure_tick(n, "tick_row3");
    check("period_row3", n, 9);
    inc_row = 1; repeat (20) step(); inc_row = 0;
    check("row_sat", row, 14);
    ld_y = 1; ld_df = 1; step(); ld_y = 0; ld_df = 0;
    check("y_row14", y_out, 0);
    measure_tick(n, "tick_row14");
    check("period_row14", n, 2);

    // Full sweep: bounce at the right wall and at zero.
    ld_x = 1; ld_d = 1; step(); ld_x = 0; ld_d = 0;
    run_until(X_MAX, "to_xmax");
    next_x(v, "after_xmax");
    check("bounce_right", v, X_MAX - 1);
    run_until(0, "to_x0");
    next_x(v, "after_x0");
    check("bounce_left", v, 1);

    // Overlap window around a block placed at 50.
    run_until(50, "to_x50");
    enable = 0; save_x = 1; step(); save_x = 0;
    check("saved_x", prev_x, 50);
    run_until(69, "to_x69");
    check("o_69", o, 1);
    run_until(70, "to_x70");
    check("o_70", o, 0);
    run_until(31, "to_x31");
    check("o_31", o, 1);
    run_until(30, "to_x30");
    check("o_30", o, 0);

    // ld_x and save_x landing on a tick.
    run_until(25, "to_x25");
    n = 0;
    while ((m_cnt + 1) % m_period != 0 && n < 50) begin step(); n++; end
    old = int'(x_out);
    ld_x = 1; save_x = 1; step(); ld_x = 0; save_x = 0;
    check("ldx_tick_x", x_out, 0);
    check("ldx_tick_prev", prev_x, old);
    enable = 0;

    // Score saturation, then game over clears progress.
    inc_score = 1; repeat (260) step(); inc_score = 0;
    check("score_sat", score, 255);
    dec_chances = 1; step(); dec_chances = 0;
    game_over = 1; inc_score = 1; inc_row = 1; save_x = 1; step();
    clear_inputs();
    check("go_score", score, 0);
    check("go_row", row, 0);
    check("go_chances", chances, 3);
    check("go_o", o, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      enable      = ($urandom_range(3) != 0);
      ld_x        = ($urandom_range(63) == 0);
      ld_d        = ($urandom_range(63) == 0);
      ld_y        = ($urandom_range(7) == 0);
      ld_df       = ($urandom_range(31) == 0);
      save_x      = ($urandom_range(15) == 0);
      inc_row     = ($urandom_range(15) == 0);
      inc_score   = ($urandom_range(3) == 0);
      dec_chances = ($urandom_range(31) == 0);
      game_over   = ($urandom_range(199) == 0);
      step();
    end
    clear_inputs();

    // Reset mid-shift aborts at once; first tick comes BASE_DIV clocks later.
    run_until(10, "to_x10");
    @(negedge clk); #2 resetn = 0;
    #1 model_reset();
    compare_all();
    check("async_rst_x", x_out, 0);
    clear_inputs();
    @(negedge clk) resetn = 1; enable = 1;
    n = 0;
    while (x_out == 8'd0 && n < 200) begin step(); n++; end
    if (x_out == 8'd0) timeout("tick_after_rst");
    check("first_tick_after_rst", n, BASE_DIV);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
